// File: rtl/tm_pkg.sv
// Shared Tsetlin Machine constants and the XIN loader state encoding.
// Imported by both the classifier and the input loader.
package tm_pkg;

   localparam int          TM_LA_CHUNKS  = 49;
   localparam int          TM_DATA_WIDTH = 32;
   localparam int          TM_ADDR_WIDTH = 6;
   localparam logic [31:0] TM_FILTER     = 32'hFFFF_FFFF;

   typedef enum logic {
      LOAD = 1'b0,
      FULL = 1'b1
   } load_state_t;

endpackage

// File: rtl/xin_bank.sv
// One literal-chunk bank: synchronous write, asynchronous read.
// Out-of-range read addresses return zero.
module xin_bank
   import tm_pkg::*;
#(
   parameter int DEPTH      = TM_LA_CHUNKS,
   parameter int DATA_WIDTH = TM_DATA_WIDTH,
   parameter int ADDR_WIDTH = TM_ADDR_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = (int'(i_rd_addr) < DEPTH) ? r_mem[i_rd_addr] : '0;

endmodule

// File: rtl/tm_xin_loader.sv
// Ping-pong input-literal loader: streams one sample into the write bank while the
// classifier reads the committed bank, then swaps and strobes tm_start.
module tm_xin_loader
   import tm_pkg::*;
#(
   parameter int                    LA_CHUNKS  = TM_LA_CHUNKS,
   parameter int                    DATA_WIDTH = TM_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = TM_ADDR_WIDTH,
   parameter logic [DATA_WIDTH-1:0] FILTER     = TM_FILTER
) (
   input  logic                  clk,
   input  logic                  rst_flag,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  tm_start,
   input  logic                  tm_done,
   output logic                  busy,
   output logic                  err,
   output logic [15:0]           frame_count
);

   localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(LA_CHUNKS - 1);

   load_state_t           r_state;
   load_state_t           w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic                  r_wr_sel;
   logic                  r_rd_sel;
   logic                  r_running;
   logic                  r_done_q;
   logic                  r_tm_start;
   logic                  r_err;
   logic [15:0]           r_frame_count;

   logic                  w_xfer;
   logic                  w_at_last;
   logic                  w_frame_err;
   logic                  w_commit;
   logic                  w_done_ev;
   logic                  w_free;
   logic                  w_swap;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [DATA_WIDTH-1:0] w_rd_data0;
   logic [DATA_WIDTH-1:0] w_rd_data1;

   assign s_ready     = rst_flag && (r_state == LOAD);
   assign w_xfer      = s_valid && s_ready;
   assign w_at_last   = (r_wr_ptr == LAST_PTR);
   assign w_frame_err = w_xfer && (s_last != w_at_last);
   assign w_commit    = w_xfer && s_last && w_at_last;
   // Edge detect so a full_done left high from the previous run cannot end the new one.
   assign w_done_ev   = tm_done && !r_done_q && r_running;
   assign w_free      = !r_running || w_done_ev;
   assign w_wr_data   = w_at_last ? (s_data & FILTER) : s_data;

   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      case (r_state)
         LOAD: begin
            if (w_commit) begin
               if (w_free) begin
                  w_swap = 1'b1;
               end else begin
                  w_state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (w_done_ev) begin
               w_swap      = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         default: w_state_nxt = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_flag) begin
         r_state       <= LOAD;
         r_wr_ptr      <= '0;
         r_wr_sel      <= 1'b1;
         r_rd_sel      <= 1'b0;
         r_running     <= 1'b0;
         r_done_q      <= 1'b0;
         r_tm_start    <= 1'b0;
         r_err         <= 1'b0;
         r_frame_count <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_done_q   <= tm_done;
         r_tm_start <= w_swap;
         if (w_frame_err) begin
            r_err <= 1'b1;
         end
         // Both a commit and a framing error restart the frame at chunk 0.
         if (w_xfer) begin
            r_wr_ptr <= (s_last || w_at_last) ? '0 : r_wr_ptr + ADDR_WIDTH'(1);
         end
         if (w_done_ev) begin
            r_running     <= 1'b0;
            r_frame_count <= r_frame_count + 16'd1;
         end
         if (w_swap) begin
            r_rd_sel  <= r_wr_sel;
            r_wr_sel  <= !r_wr_sel;
            r_running <= 1'b1;
         end
      end
   end

   xin_bank #(
      .DEPTH      (LA_CHUNKS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank0 (
      .i_clk     (clk),
      .i_we      (w_xfer && !r_wr_sel),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (rd_addr),
      .o_rd_data (w_rd_data0)
   );

   xin_bank #(
      .DEPTH      (LA_CHUNKS),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank1 (
      .i_clk     (clk),
      .i_we      (w_xfer && r_wr_sel),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (rd_addr),
      .o_rd_data (w_rd_data1)
   );

   assign rd_data     = r_rd_sel ? w_rd_data1 : w_rd_data0;
   assign tm_start    = r_tm_start;
   assign busy        = r_running;
   assign err         = r_err;
   assign frame_count = r_frame_count;

endmodule

// File: tb/tb_tm_xin_loader.sv
// Bench for tm_xin_loader: directed scenarios plus random traffic against a
// frame-level reference model of the double-buffered loader.
module tb_tm_xin_loader;

   localparam int          N    = 49;
   localparam logic [31:0] FILT = 32'h0000_FFFF;

   logic        clk = 1'b0;
   logic        rst_flag = 1'b0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_last = 1'b0;
   logic        s_ready;
   logic [5:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        tm_start;
   logic        tm_done = 1'b0;
   logic        busy;
   logic        err;
   logic [15:0] frame_count;

   always #5 clk = ~clk;

   tm_xin_loader #(
      .LA_CHUNKS  (N),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (6),
      .FILTER     (FILT)
   ) dut (
      .clk         (clk),
      .rst_flag    (rst_flag),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .tm_start    (tm_start),
      .tm_done     (tm_done),
      .busy        (busy),
      .err         (err),
      .frame_count (frame_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the frame being shown to the classifier, the frame being
   // assembled, and at most one completed frame waiting for the classifier.
   logic [31:0] m_disp [N];
   logic [31:0] m_load [N];
   logic [31:0] m_pend [N];
   bit          m_disp_ok;
   bit          m_pending;
   bit          m_running;
   bit          m_prev_done;
   bit          m_err;
   bit          m_start;
   int          m_wptr;
   logic [15:0] m_count;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_edge();
      bit ready;
      bit was_running;
      bit done_ev;
      bit last_pos;
      if (!rst_flag) begin
         m_wptr = 0; m_running = 0; m_err = 0; m_count = '0;
         m_pending = 0; m_start = 0; m_prev_done = 0; m_disp_ok = 0;
         return;
      end
      ready       = !m_pending;
      was_running = m_running;
      done_ev     = tm_done && !m_prev_done && m_running;
      m_start     = 0;
      if (done_ev) begin
         m_running = 0;
         m_count   = m_count + 16'd1;
      end
      if (m_pending && done_ev) begin
         m_disp = m_pend; m_disp_ok = 1; m_running = 1; m_start = 1; m_pending = 0;
      end
      if (s_valid && ready) begin
         last_pos = (m_wptr == N - 1);
         m_load[m_wptr] = last_pos ? (s_data & FILT) : s_data;
         if (s_last != last_pos) begin
            m_err  = 1;
            m_wptr = 0;
         end else if (last_pos) begin
            m_wptr = 0;
            if (!was_running || done_ev) begin
               m_disp = m_load; m_disp_ok = 1; m_running = 1; m_start = 1;
            end else begin
               m_pend = m_load; m_pending = 1;
            end
         end else begin
            m_wptr++;
         end
      end
      m_prev_done = tm_done;
   endtask

   task automatic check_all();
      check("s_ready", 32'(s_ready), rst_flag ? 32'(!m_pending) : 32'd0);
      check("tm_start", 32'(tm_start), 32'(m_start));
      check("busy", 32'(busy), 32'(m_running));
      check("err", 32'(err), 32'(m_err));
      check("frame_count", 32'(frame_count), 32'(m_count));
      if (int'(rd_addr) >= N) check("rd_data_oor", rd_data, 32'd0);
      else if (m_disp_ok) check("rd_data", rd_data, m_disp[rd_addr]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic peek(input string tag, input logic [5:0] a, input logic [31:0] exp);
      logic [5:0] save;
      save    = rd_addr;
      rd_addr = a;
      #1;
      check(tag, rd_data, exp);
      rd_addr = save;
   endtask

   task automatic send_word(input logic [31:0] d, input logic last);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      step();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   initial begin
      // Reset
      rst_flag = 1'b0;
      repeat (3) step();
      check("s_ready_in_reset", 32'(s_ready), 32'd0);
      rst_flag = 1'b1;
      step();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_count", 32'(frame_count), 32'd0);
      check("rst_start", 32'(tm_start), 32'd0);

      // Frame 1 into an idle classifier
      for (int i = 0; i < N; i++) send_word(32'(i), i == N - 1);
      check("f1_start", 32'(tm_start), 32'd1);
      check("f1_busy", 32'(busy), 32'd1);
      peek("f1_rd5", 6'd5, 32'd5);
      step();
      check("f1_start_drop", 32'(tm_start), 32'd0);

      // Frame 2 while busy; last word exercises the filter
      for (int i = 0; i < N; i++)
         send_word((i == N - 1) ? 32'hDEAD_BEEF : 32'(100 + i), i == N - 1);
      check("f2_ready_low", 32'(s_ready), 32'd0);
      check("f2_no_start", 32'(tm_start), 32'd0);
      peek("f2_old_rd5", 6'd5, 32'd5);
      peek("f2_old_rd48", 6'd48, 32'd48);
      step();
      tm_done = 1'b1;
      step();
      tm_done = 1'b0;
      check("f2_start", 32'(tm_start), 32'd1);
      check("f2_count", 32'(frame_count), 32'd1);
      check("f2_ready", 32'(s_ready), 32'd1);
      peek("f2_filter", 6'd48, 32'h0000_BEEF);
      peek("f2_rd5", 6'd5, 32'd105);
      step();

      // Early s_last: framing error, then a clean frame
      for (int i = 0; i <= 10; i++) send_word(32'(500 + i), i == 10);
      check("ferr_err", 32'(err), 32'd1);
      check("ferr_no_start", 32'(tm_start), 32'd0);
      tm_done = 1'b1;
      step();
      tm_done = 1'b0;
      step();
      check("ferr_count", 32'(frame_count), 32'd2);
      for (int i = 0; i < N; i++) send_word(32'(200 + i), i == N - 1);
      check("f3_start", 32'(tm_start), 32'd1);
      check("f3_err_sticky", 32'(err), 32'd1);
      peek("f3_rd0", 6'd0, 32'd200);
      step();

      // Final transfer coincides with the done event
      for (int i = 0; i < N - 1; i++) send_word(32'(300 + i), 1'b0);
      tm_done = 1'b1;
      send_word(32'(300 + N - 1), 1'b1);
      tm_done = 1'b0;
      check("sim_start", 32'(tm_start), 32'd1);
      check("sim_count", 32'(frame_count), 32'd3);
      check("sim_ready", 32'(s_ready), 32'd1);
      peek("sim_rd48", 6'd48, 32'd348);
      step();

      // Reset mid-frame
      for (int i = 0; i < 20; i++) send_word(32'(700 + i), 1'b0);
      rst_flag = 1'b0;
      step();
      step();
      rst_flag = 1'b1;
      step();
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_err", 32'(err), 32'd0);
      check("mrst_ready", 32'(s_ready), 32'd1);
      check("mrst_count", 32'(frame_count), 32'd0);
      for (int i = 0; i < N; i++) begin
         send_word(32'(800 + i), i == N - 1);
         if (i == N - 2) check("mrst_no_early_start", 32'(tm_start), 32'd0);
      end
      check("mrst_start", 32'(tm_start), 32'd1);
      check("mrst_err_clean", 32'(err), 32'd0);
      peek("mrst_rd7", 6'd7, 32'd807);
      step();

      // Random traffic
      for (int c = 0; c < 4000; c++) begin
         rst_flag = ($urandom_range(0, 599) != 0);
         s_valid  = ($urandom_range(0, 3) != 0);
         s_data   = $urandom;
         s_last   = (m_wptr == N - 1) ^ ($urandom_range(0, 59) == 0);
         tm_done  = ($urandom_range(0, 39) == 0);
         rd_addr  = 6'($urandom_range(0, 63));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
